dual_rail_tx: RTL and testbench
===============================

Name: dual_rail_tx

Overview:
- Synchronous-to-dual-rail transmitter. Converts a single-rail word, accepted on a valid/ready interface, into a dual-rail (1-of-2 per bit) codeword for the threshold-gate ALU datapath.
- Implements the 4-phase return-to-zero protocol: DATA, wait for ack rise, SPACER (all-zero), wait for ack fall.
- Sits at the clocked boundary and drives operand/select inputs of the dual-rail ALU and detectors. The downstream completion detector provides ack.

Parameters:
- WIDTH, 2, number of single-rail bits; dual-rail output is 2*WIDTH wires.
- SYNC_STAGES, 2, flip-flop stages synchronizing ack into clk domain (>=2).
- SPACER_MIN, 1, minimum clk cycles SPACER is held before returning to IDLE (>=1).
- TIMEOUT, 255, cycles waiting on ack in DATA or SPACER before err is set (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  single-rail word to send.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word.
- dr_out  output  2*WIDTH  dual-rail codeword; bit i -> dr_out[2i+1]=true rail, dr_out[2i]=false rail.
- ack  input  1  completion from receiver; asynchronous, synchronized internally.
- done  output  1  one-cycle pulse when a full 4-phase cycle completes.
- err  output  1  sticky timeout flag.
- err_clr  input  1  synchronous clear of err.

Behaviour:
- Reset: asynchronous on rst_n low, regardless of state.
  - dr_out=0 (spacer), in_ready=0, done=0, err=0.
  - State IDLE; counters and sync flops cleared.
  - Reset mid-handshake drops dr_out to spacer immediately. This is a legal null wavefront.
  - in_ready rises the first cycle after reset release, provided ack_s=0.
- ack_s is ack after SYNC_STAGES flops. All decisions use ack_s only.
- All outputs are registered. dr_out never changes in the same cycle as the decision input that causes the change.
- Encoding:
  - bit=1 -> {t,f}=10; bit=0 -> {t,f}=01.
  - 11 is never driven. 00 appears on all pairs together only (spacer).
  - dr_out never transitions directly DATA->DATA; a spacer always separates codewords.
- States:
  - IDLE:
    - in_ready = (ack_s==0).
    - On in_valid && in_ready at edge k: latch in_data, dr_out=encoded word from edge k, go to DATA, wait counter cleared.
    - If ack_s==1 in IDLE, in_ready=0 until it falls. This protects against a receiver not yet reset to null.
  - DATA:
    - in_ready=0; dr_out holds the codeword.
    - When ack_s==1: dr_out=0 at that edge, go to SPACER, spacer counter=1, wait counter cleared.
  - SPACER:
    - dr_out=0; spacer counter saturates at SPACER_MIN.
    - When ack_s==0 and spacer counter>=SPACER_MIN: go to IDLE, done=1 for one cycle.
    - in_ready may assert in that same cycle, so back-to-back transfers are possible.
- Timeout:
  - The wait counter increments each cycle in DATA or SPACER while the awaited ack level is absent, and saturates at TIMEOUT.
  - Reaching TIMEOUT sets err. The state machine does not abort and keeps waiting.
  - err_clr clears err. If set and clear coincide, set wins.
- in_valid and in_data are ignored outside the IDLE accept cycle. Changes to in_data after acceptance do not affect dr_out.
- Minimum transfer period with an ideal receiver (ack toggles as soon as it sees the wavefront): approximately 2*(SYNC_STAGES+1)+SPACER_MIN cycles.

Test Plan:
- Reset/idle:
  - Stimulus: hold rst_n=0 5 cycles, then release with ack=0.
  - Required: dr_out=4'b0000, err=0, done=0 throughout reset; in_ready=1 on the first cycle after release.
- Single transfer, WIDTH=2:
  - Stimulus: in_data=2'b10, in_valid pulse. Ack model raises ack 3 cycles after seeing data and drops it 3 cycles after seeing spacer.
  - Required: dr_out=4'b1001 from the accept edge until SYNC_STAGES cycles after ack rise, then 4'b0000; exactly one done pulse; in_ready=0 for the whole handshake.
- Back-to-back transfers:
  - Stimulus: in_valid held high with words 00, 11, 01.
  - Required: dr_out sequence 0101, 0000, 1010, 0000, 0110, 0000 with no direct data-to-data change; 3 done pulses.
- Stuck ack high at idle:
  - Stimulus: ack=1 after reset.
  - Required: in_ready=0 and dr_out=0 until ack falls; in_ready=1 SYNC_STAGES+1 cycles after the fall.
- Timeout:
  - Stimulus: TIMEOUT=8, send 2'b01, never raise ack.
  - Required: dr_out stays 4'b0110; err=1 after 8 waiting cycles. Asserting err_clr clears err for one cycle, after which err re-asserts because the counter is saturated. A later ack rise still completes the handshake.
- Reset mid-DATA:
  - Stimulus: pull rst_n low while dr_out=4'b1010.
  - Required: dr_out=0 asynchronously, before the next clk edge; after release, state is IDLE and no done pulse is produced.

Source files
------------

// File: rtl/dual_rail_tx.sv
// dual_rail_tx
//   Clocked single-rail to dual-rail (1-of-2 per bit) transmitter running the
//   4-phase return-to-zero protocol: DATA, wait ack high, SPACER, wait ack low.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset; drops dr_out to spacer at once
//   in_data   single-rail word to send
//   in_valid  in_data valid
//   in_ready  block can accept a word (registered)
//   dr_out    dual-rail codeword, bit i -> {dr_out[2i+1] true, dr_out[2i] false}
//   ack       completion from the receiver (asynchronous, synchronized here)
//   done      one-cycle pulse when a full 4-phase cycle completes
//   err       sticky timeout flag
//   err_clr   synchronous clear of err
//   dbgState  current FSM state, for observation only
//
// Handshake: a word transfers on a rising clk edge where in_valid and
// in_ready are both high; in_valid/in_data are ignored on every other edge,
// and in_ready never depends combinationally on in_valid.

module dual_rail_tx #(
   parameter int WIDTH       = 2,
   parameter int SYNC_STAGES = 2,
   parameter int SPACER_MIN  = 1,
   parameter int TIMEOUT     = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [2*WIDTH-1:0]   dr_out,
   input  logic                 ack,
   output logic                 done,
   output logic                 err,
   input  logic                 err_clr,
   output logic [1:0]           dbgState
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam int SP_W   = $clog2(SPACER_MIN + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
   localparam logic [SP_W-1:0]   SP_MAX   = SP_W'(SPACER_MIN);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] SPACER = 2'd2;

   logic [SYNC_STAGES-1:0] ackSync;
   logic                   ackS;
   logic [1:0]             state, stateNext;
   logic [2*WIDTH-1:0]     drNext;
   logic [SP_W-1:0]        spCnt, spNext;
   logic [WAIT_W-1:0]      waitCnt, waitNext, waitInc;
   logic                   readyNext, doneNext, errNext;
   logic                   errReach, errHold;

   assign ackS     = ackSync[SYNC_STAGES-1];
   assign dbgState = state;
   assign waitInc  = (waitCnt == WAIT_MAX) ? waitCnt : waitCnt + WAIT_W'(1);

   function automatic logic [2*WIDTH-1:0] encode(input logic [WIDTH-1:0] d);
      logic [2*WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH; i++) begin
         r[2*i+1] = d[i];
         r[2*i]   = ~d[i];
      end
      return r;
   endfunction

   always_comb begin
      stateNext = state;
      drNext    = dr_out;
      spNext    = spCnt;
      waitNext  = waitCnt;
      doneNext  = 1'b0;
      case (state)
         IDLE: begin
            waitNext = '0;
            if (in_valid && in_ready) begin
               stateNext = DATA;
               drNext    = encode(in_data);
            end
         end
         DATA: begin
            if (ackS) begin
               stateNext = SPACER;
               drNext    = '0;
               spNext    = SP_W'(1);
               waitNext  = '0;
            end else begin
               waitNext = waitInc;
            end
         end
         SPACER: begin
            if (!ackS && (spCnt >= SP_MAX)) begin
               stateNext = IDLE;
               doneNext  = 1'b1;
               waitNext  = '0;
            end else begin
               if (spCnt < SP_MAX) spNext = spCnt + SP_W'(1);
               // ack already low but spacer not yet held long enough is
               // not a wait on the receiver, so the counter holds
               if (ackS) waitNext = waitInc;
            end
         end
         default: begin
            stateNext = IDLE;
            drNext    = '0;
         end
      endcase

      // in_ready stays low while the receiver still reports a wavefront,
      // so a receiver not yet back at null never sees fresh data
      readyNext = (stateNext == IDLE) && !ackS;

      // Reaching the limit sets err even against err_clr; once saturated
      // the flag re-asserts on the cycle after a clear while still waiting.
      errReach = (waitNext == WAIT_MAX) && (waitCnt != WAIT_MAX);
      errHold  = (waitNext == WAIT_MAX);
      errNext  = errReach | (!err_clr & (err | errHold));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ackSync  <= '0;
         state    <= IDLE;
         dr_out   <= '0;
         spCnt    <= '0;
         waitCnt  <= '0;
         in_ready <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         ackSync  <= {ackSync[SYNC_STAGES-2:0], ack};
         state    <= stateNext;
         dr_out   <= drNext;
         spCnt    <= spNext;
         waitCnt  <= waitNext;
         in_ready <= readyNext;
         done     <= doneNext;
         err      <= errNext;
      end
   end

endmodule

// File: tb/tb_dual_rail_tx.sv
module tb_dual_rail_tx;

   localparam int WIDTH = 2;
   localparam int SYNC  = 2;
   localparam int SPMIN = 1;
   localparam int TOUT  = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [WIDTH-1:0]   in_data;
   logic               in_valid;
   logic               in_ready;
   logic [2*WIDTH-1:0] dr_out;
   logic               ack;
   logic               done;
   logic               err;
   logic               err_clr;
   logic [1:0]         dbgState;

   dual_rail_tx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .SPACER_MIN(SPMIN), .TIMEOUT(TOUT)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .dr_out(dr_out), .ack(ack), .done(done),
      .err(err), .err_clr(err_clr), .dbgState(dbgState)
   );

   // ---------------- scoreboard state ----------------
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic [2*WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0]   txQ[$];
   logic [2*WIDTH-1:0] prevDr = '0;
   int pendingDone = 0;
   int doneCount = 0;
   int riseCyc = 0, fallCyc = 0;
   bit riseArmed = 0, fallArmed = 0;
   bit rxOn = 0, rxRand = 0, gaps = 0;
   int rxCnt = 0, rxDelay = 3;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Spec encoding: bit 1 -> {t,f}=10, bit 0 -> {t,f}=01
   function automatic logic [2*WIDTH-1:0] enc(input logic [WIDTH-1:0] d);
      logic [2*WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) r[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
      return r;
   endfunction

   // Either all pairs null, or every pair carries exactly one hot rail
   function automatic logic legal(input logic [2*WIDTH-1:0] d);
      logic ok;
      logic [1:0] p;
      ok = 1'b1;
      if (d != '0)
         for (int i = 0; i < WIDTH; i++) begin
            p = d[2*i +: 2];
            if (p == 2'b00 || p == 2'b11) ok = 1'b0;
         end
      return ok;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic setAck(input logic v);
      if (v && !ack) begin riseCyc = cyc; riseArmed = (dr_out != '0); end
      if (!v && ack) begin fallCyc = cyc; fallArmed = (pendingDone > 0); end
      ack = v;
      rxCnt = 0;
      if (rxRand) rxDelay = $urandom_range(0, 4);
   endtask

   task automatic feed();
      logic [31:0] r;
      r = $urandom;
      in_valid = (txQ.size() > 0) && (!gaps || ($urandom_range(0, 3) != 0));
      in_data  = in_valid ? txQ[0] : r[WIDTH-1:0];
   endtask

   // One clock: note acceptance, advance, check invariants, run receiver, feed
   task automatic step();
      logic acc;
      logic [2*WIDTH-1:0] accWord;
      acc = in_valid && in_ready && rst_n;
      accWord = enc(in_data);
      if (acc) begin
         exp_q.push_back(accWord);
         if (txQ.size() > 0) void'(txQ.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("pair_legal", legal(dr_out), 1);
      if (acc) chk("accept_to_data", dr_out, accWord);
      if (dr_out != prevDr) begin
         if (dr_out != '0) begin
            chk("no_data_to_data", prevDr, 0);
            if (exp_q.size() == 0) chk("codeword_unexpected", dr_out, 0);
            else begin
               chk("codeword", dr_out, exp_q.pop_front());
               pendingDone++;
            end
         end else if (riseArmed) begin
            chk("ack_rise_to_spacer", cyc - riseCyc, SYNC + 1);
            riseArmed = 0;
         end
      end
      if (!done && pendingDone > 0) chk("ready_low_busy", in_ready, 0);
      if (done) begin
         chk("done_expected", pendingDone > 0, 1);
         if (pendingDone > 0) pendingDone--;
         if (fallArmed) chk("ack_fall_to_done", cyc - fallCyc, SYNC + 1);
         fallArmed = 0;
         doneCount++;
      end
      prevDr = dr_out;
      if (rxOn) begin
         if (!ack && dr_out != '0) begin
            if (rxCnt >= rxDelay) setAck(1'b1); else rxCnt++;
         end else if (ack && dr_out == '0) begin
            if (rxCnt >= rxDelay) setAck(1'b0); else rxCnt++;
         end else rxCnt = 0;
      end
      feed();
   endtask

   task automatic waitIdle(input int budget, input string tag);
      int n = 0;
      while (!(txQ.size() == 0 && exp_q.size() == 0 && pendingDone == 0 && !in_valid) && n < budget) begin
         step();
         n++;
      end
      chk(tag, n < budget, 1);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int d0;
      logic [31:0] r;
      rst_n = 1'b0; ack = 1'b0; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;

      // Reset / idle
      repeat (5) begin
         step();
         chk("rst_dr_out", dr_out, 0);
         chk("rst_err", err, 0);
         chk("rst_done", done, 0);
         chk("rst_ready", in_ready, 0);
      end
      rst_n = 1'b1;
      step();
      chk("ready_after_reset", in_ready, 1);

      // Single transfer of 2'b10, receiver answers 3 cycles after each wavefront
      rxOn = 1; rxDelay = 3;
      d0 = doneCount;
      txQ.push_back(2'b10); feed();
      step();
      chk("single_code", dr_out, 4'b1001);
      waitIdle(60, "single_complete");
      chk("single_done_count", doneCount - d0, 1);

      // Back-to-back with in_valid held high
      d0 = doneCount;
      txQ.push_back(2'b00); txQ.push_back(2'b11); txQ.push_back(2'b01); feed();
      waitIdle(150, "b2b_complete");
      chk("b2b_done_count", doneCount - d0, 3);

      // Ack stuck high while idle
      rxOn = 0;
      setAck(1'b1);
      repeat (SYNC + 1) step();
      txQ.push_back(2'b11); feed();
      repeat (8) begin
         step();
         chk("stuck_ready", in_ready, 0);
         chk("stuck_dr_out", dr_out, 0);
      end
      setAck(1'b0);
      repeat (SYNC) begin
         step();
         chk("stuck_ready_sync", in_ready, 0);
      end
      step();
      chk("stuck_ready_release", in_ready, 1);
      rxOn = 1; rxCnt = 0;
      waitIdle(60, "stuck_complete");

      // Timeout: never raise ack, err after TOUT waiting cycles
      rxOn = 0;
      txQ.push_back(2'b01); feed();
      step();
      chk("to_code", dr_out, 4'b0110);
      for (int k = 1; k < TOUT; k++) begin
         step();
         chk("to_err_early", err, 0);
         chk("to_dr_hold", dr_out, 4'b0110);
      end
      step();
      chk("to_err_set", err, 1);
      repeat (3) begin
         step();
         chk("to_err_hold", err, 1);
      end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("to_err_cleared", err, 0);
      step();
      chk("to_err_reassert", err, 1);
      chk("to_dr_still", dr_out, 4'b0110);
      d0 = doneCount;
      setAck(1'b1);
      rxOn = 1;
      waitIdle(60, "to_complete");
      chk("to_done_count", doneCount - d0, 1);
      chk("to_err_sticky", err, 1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("to_err_clr_idle", err, 0);
      step();
      chk("to_err_stays_clr", err, 0);

      // Reset in the middle of DATA
      rxOn = 0;
      txQ.push_back(2'b11); feed();
      step();
      chk("rmid_code", dr_out, 4'b1010);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rmid_async_dr", dr_out, 0);
      chk("rmid_done", done, 0);
      chk("rmid_ready", in_ready, 0);
      exp_q.delete(); pendingDone = 0; riseArmed = 0; fallArmed = 0;
      repeat (2) step();
      rst_n = 1'b1;
      d0 = doneCount;
      step();
      chk("rmid_ready_after", in_ready, 1);
      repeat (6) step();
      chk("rmid_no_done", doneCount - d0, 0);
      chk("rmid_idle_dr", dr_out, 0);

      // Randomized traffic with random receiver delays and valid gaps
      rxOn = 1; rxRand = 1; gaps = 1; rxCnt = 0;
      d0 = doneCount;
      for (int i = 0; i < 30; i++) begin
         r = $urandom;
         txQ.push_back(r[WIDTH-1:0]);
      end
      feed();
      waitIdle(3000, "rand_complete");
      chk("rand_done_count", doneCount - d0, 30);
      chk("final_err_clear", err, 0);
      chk("exp_q_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed running expected finished");
      $fatal(1, "watchdog expired");
   end

endmodule
